// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: compare-target encodings, command
// key codes and the factory code defaults.
package lock_pkg;

  typedef enum logic [1:0] {
    COMPAREPC = 2'b00,
    COMPAREUC = 2'b01,
    MATCHUC   = 2'b10,
    STOREUC   = 2'b11
  } cmp_type_e;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_PROG   = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;

  localparam logic [31:0] PC_CODE    = 32'h0012_3456;
  localparam logic [31:0] UC_DEFAULT = 32'h0000_1234;

endpackage

// File: rtl/code_entry_compare_key_event_detect.sv
// Release-edge key detector: one event per key release, with the key value
// and a flag telling whether it is one of the command keys.
module key_event_detect
  import lock_pkg::*;
(
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic       bstate,
  output logic       key_evt,
  output logic [3:0] key_val,
  output logic       is_cmd
);

  logic prev_bstate_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge hwclk) begin
    if (reset) prev_bstate_q <= 1'b0;
    else       prev_bstate_q <= bstate;
  end

  assign key_evt = prev_bstate_q & ~bstate;
  assign key_val = button;
  assign is_cmd  = key_evt &&
                   (button == KEY_CANCEL || button == KEY_PROG || button == KEY_LOCK);

endmodule

// File: rtl/code_entry_compare.sv
// Keypad entry buffer and code comparator feeding the lock controller.
// Holds the entry, the active user code and a reprogramming candidate.
module code_entry_compare
  import lock_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int MIN_LEN        = 4,
  parameter int PC_LEN         = 6,
  parameter logic [4*MAX_LEN-1:0] PC_CODE    = lock_pkg::PC_CODE,
  parameter logic [4*MAX_LEN-1:0] UC_DEFAULT = lock_pkg::UC_DEFAULT,
  parameter int UC_DEFAULT_LEN = 4
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic       bstate,
  input  logic       read_input,
  input  logic [1:0] compareType,
  input  logic       store,
  output logic       correct_input,
  output logic       data_ready,
  output logic       validLength,
  output logic       validLengthPC
);

  localparam int W  = 4 * MAX_LEN;
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [LW-1:0] MAX_L  = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L  = LW'(MIN_LEN);
  localparam logic [LW-1:0] PC_L   = LW'(PC_LEN);
  localparam logic [LW-1:0] UC_D_L = LW'(UC_DEFAULT_LEN);
  localparam logic [LW-1:0] ONE_L  = LW'(1);

  logic       key_evt;
  logic [3:0] key_val;
  logic       is_cmd;

  key_event_detect u_key_event_detect (
    .hwclk   (hwclk),
    .reset   (reset),
    .button  (button),
    .bstate  (bstate),
    .key_evt (key_evt),
    .key_val (key_val),
    .is_cmd  (is_cmd)
  );

  logic [W-1:0]  entry_q, entry_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          fresh_q, fresh_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [LW-1:0] cand_len_q, cand_len_d;
  logic [W-1:0]  uc_q, uc_d;
  logic [LW-1:0] uc_len_q, uc_len_d;
  logic          correct_q, correct_d;

  // Length flags depend only on registered state, so they hold steady
  // between a command key and the next accepted digit.
  assign validLength   = (len_q >= MIN_L) && (len_q <= MAX_L) && !ovf_q;
  assign validLengthPC = (len_q == PC_L) && !ovf_q;
  assign data_ready    = fresh_q && (len_q != '0);
  assign correct_input = correct_q;

  // NOTE: every variable gets its hold value first so no path through the
  // conditionals leaves it unassigned, which would infer a latch.
  always_comb begin
    entry_d    = entry_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    fresh_d    = fresh_q;
    cand_d     = cand_q;
    cand_len_d = cand_len_q;
    uc_d       = uc_q;
    uc_len_d   = uc_len_q;

    if (store) begin
      uc_d     = cand_q;
      uc_len_d = cand_len_q;
    end

    if (key_evt) begin
      if (is_cmd) begin
        fresh_d = 1'b1;
        if (key_val == KEY_PROG && cmp_type_e'(compareType) == STOREUC && validLength) begin
          cand_d     = entry_q;
          cand_len_d = len_q;
        end
      end else if (read_input) begin
        if (fresh_q) begin
          entry_d = {{(W-4){1'b0}}, key_val};
          len_d   = ONE_L;
          ovf_d   = 1'b0;
          fresh_d = 1'b0;
        end else if (len_q < MAX_L) begin
          entry_d = {entry_q[W-5:0], key_val};
          len_d   = len_q + ONE_L;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  logic [W-1:0]  tgt_val;
  logic [LW-1:0] tgt_len;
  logic          tgt_en;

  always_comb begin
    tgt_val = '0;
    tgt_len = '0;
    tgt_en  = 1'b0;
    case (cmp_type_e'(compareType))
      COMPAREPC: begin tgt_val = PC_CODE; tgt_len = PC_L;       tgt_en = 1'b1; end
      COMPAREUC: begin tgt_val = uc_q;    tgt_len = uc_len_q;   tgt_en = 1'b1; end
      MATCHUC:   begin tgt_val = cand_q;  tgt_len = cand_len_q; tgt_en = 1'b1; end
      default:   tgt_en = 1'b0;
    endcase
    correct_d = tgt_en && (entry_q == tgt_val) && (len_q == tgt_len) && !ovf_q;
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      entry_q    <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      fresh_q    <= 1'b1;
      cand_q     <= '0;
      cand_len_q <= '0;
      uc_q       <= UC_DEFAULT;
      uc_len_q   <= UC_D_L;
      correct_q  <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      fresh_q    <= fresh_d;
      cand_q     <= cand_d;
      cand_len_q <= cand_len_d;
      uc_q       <= uc_d;
      uc_len_q   <= uc_len_d;
      correct_q  <= correct_d;
    end
  end

endmodule

// File: tb/tb_code_entry_compare.sv
// Scoreboard bench for code_entry_compare: a digit-list reference model
// predicts each cycle's outputs, a monitor compares them on the falling edge.
module tb_code_entry_compare;

  logic       hwclk = 1'b0;
  logic       reset;
  logic [3:0] button;
  logic       bstate;
  logic       read_input;
  logic [1:0] compareType;
  logic       store;
  logic       correct_input, data_ready, validLength, validLengthPC;

  code_entry_compare dut (
    .hwclk         (hwclk),
    .reset         (reset),
    .button        (button),
    .bstate        (bstate),
    .read_input    (read_input),
    .compareType   (compareType),
    .store         (store),
    .correct_input (correct_input),
    .data_ready    (data_ready),
    .validLength   (validLength),
    .validLengthPC (validLengthPC)
  );

  always #5 hwclk = ~hwclk;

  typedef struct {
    logic ci;
    logic dr;
    logic vl;
    logic vlpc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // stimulus values applied by tick()
  logic       t_reset = 1'b1;
  logic [3:0] t_button = 4'd0;
  logic       t_bstate = 1'b0;
  logic       t_read = 1'b1;
  logic [1:0] t_ct = 2'd1;
  logic       t_store = 1'b0;

  // reference model: codes held as lists of digits, most significant first
  int ent[$];
  int cnd[$];
  int ucq[$];
  int pcq[$] = '{1, 2, 3, 4, 5, 6};
  bit m_ovf, m_fresh, m_prev, m_corr, m_valid = 1'b0;

  function automatic bit same_code(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_vl();
    return ent.size() >= 4 && ent.size() <= 8 && !m_ovf;
  endfunction

  task automatic model_step();
    bit corr_n, evt;
    int k;
    int new_uc[$];
    if (t_reset) begin
      ent = {};
      cnd = {};
      ucq = '{1, 2, 3, 4};
      m_ovf = 0; m_fresh = 1; m_prev = 0; m_corr = 0;
      return;
    end
    case (t_ct)
      2'd0:    corr_n = !m_ovf && same_code(ent, pcq);
      2'd1:    corr_n = !m_ovf && same_code(ent, ucq);
      2'd2:    corr_n = !m_ovf && same_code(ent, cnd);
      default: corr_n = 1'b0;
    endcase
    new_uc = t_store ? cnd : ucq;
    evt = m_prev && !t_bstate;
    m_prev = t_bstate;
    if (evt) begin
      k = int'(t_button);
      if (k >= 7 && k <= 9) begin
        if (k == 8 && t_ct == 2'd3 && m_vl()) cnd = ent;
        m_fresh = 1;
      end else if (t_read) begin
        if (m_fresh) begin
          ent = '{k};
          m_ovf = 0;
          m_fresh = 0;
        end else if (ent.size() < 8) ent.push_back(k);
        else m_ovf = 1;
      end
    end
    ucq = new_uc;
    m_corr = corr_n;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge hwclk);
    #1;
    if (m_valid) begin
      e.ci   = m_corr;
      e.dr   = m_fresh && ent.size() != 0;
      e.vl   = m_vl();
      e.vlpc = ent.size() == 6 && !m_ovf;
      sb.push_back(e);
    end
    reset       = t_reset;
    button      = t_button;
    bstate      = t_bstate;
    read_input  = t_read;
    compareType = t_ct;
    store       = t_store;
    model_step();
    m_valid = 1'b1;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    t_button = k;
    t_bstate = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    t_bstate = 1'b0;
    tick();
    tick();
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) press(4'(keys[i]), 2);
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge hwclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("correct_input", 32'(correct_input), 32'(e.ci));
        check("data_ready",    32'(data_ready),    32'(e.dr));
        check("validLength",   32'(validLength),   32'(e.vl));
        check("validLengthPC", 32'(validLengthPC), 32'(e.vlpc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; button = '0; bstate = 1'b0; read_input = 1'b1;
    compareType = 2'd1; store = 1'b0;

    t_reset = 1'b1; tick(); tick();
    t_reset = 1'b0; tick(); tick();

    // default user code, then programming code of the right and wrong length
    t_ct = 2'd1; press_seq('{1, 2, 3, 4, 9});
    t_ct = 2'd0; press_seq('{1, 2, 3, 4, 5, 6, 8});
    press_seq('{1, 2, 3, 4, 5, 8});

    // reprogram to 5566, confirm, commit, old code now rejected
    t_ct = 2'd3; press_seq('{5, 5, 6, 6, 8});
    t_ct = 2'd2; press_seq('{5, 5, 6, 6, 8});
    t_store = 1'b1; tick(); t_store = 1'b0; tick();
    t_ct = 2'd1; press_seq('{1, 2, 3, 4, 9});
    press_seq('{5, 5, 6, 6, 9});

    // overflow then fresh clear
    press_seq('{1, 2, 3, 4, 5, 6, 0, 10, 11, 7, 3});
    // command keys on an empty-after-reset buffer
    t_reset = 1'b1; tick(); t_reset = 1'b0;
    press_seq('{7, 8, 9});

    // gated digits, then reset mid-entry
    t_read = 1'b0; press_seq('{1, 2});
    t_read = 1'b1; press_seq('{1, 2, 3});
    t_reset = 1'b1; tick(); t_reset = 1'b0; tick(); tick();
    t_ct = 2'd1; press_seq('{1, 2, 3, 4, 9});

    // store held while key 8 stores a new candidate
    t_ct = 2'd3; press_seq('{12, 13, 14, 15});
    t_store = 1'b1; press(4'd8, 2); tick(); t_store = 1'b0;
    t_ct = 2'd1; press_seq('{12, 13, 14, 15, 9});

    // randomized presses
    for (int n = 0; n < 300; n++) begin
      t_read  = ($urandom_range(0, 9) != 0);
      t_ct    = 2'($urandom_range(0, 3));
      t_store = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        t_reset = 1'b1; tick(); t_reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0)
        press(4'($urandom_range(7, 9)), $urandom_range(1, 3));
      else
        press(4'($urandom_range(0, 15)), $urandom_range(1, 3));
    end
    t_store = 1'b0;
    tick(); tick();

    @(negedge hwclk);
    @(negedge hwclk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
